// File: rtl/regfile_sb.sv
// Register file with NRD combinational read ports, one byte-enabled write
// port, write-to-read bypass and a per-register busy scoreboard.
// Register 0 is hardwired to zero and never reports busy.

// One read port: stored value with same-cycle write bytes merged in.
module regfile_sb_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] regs,
  input  logic [(1<<ADDR_W)-1:0]             busy,
  input  logic [ADDR_W-1:0]                  raddr,
  input  logic                               we,
  input  logic [ADDR_W-1:0]                  waddr,
  input  logic [DATA_W/8-1:0]                wbe,
  input  logic [DATA_W-1:0]                  wdata,
  output logic [DATA_W-1:0]                  rdata,
  output logic                               rbusy
);
  localparam int NB = DATA_W / 8;

  logic byp;

  // A write landing on this address this cycle is visible immediately
  assign byp = we && (waddr == raddr) && (raddr != '0);

  // Read mux with bytewise bypass; r0 forced to zero and never busy
  always_comb begin
    rdata = '0;
    rbusy = 1'b0;
    if (raddr != '0) begin
      rdata = regs[raddr];
      if (byp) begin
        for (int b = 0; b < NB; b++)
          if (wbe[b]) rdata[8*b +: 8] = wdata[8*b +: 8];
      end
      // the clear from a completing write is forwarded, a new issue is not
      rbusy = busy[raddr] & ~byp;
    end
  end
endmodule

module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_W/8-1:0]   wbe,
  input  logic [DATA_W-1:0]     wdata,
  input  logic                  iss,
  input  logic [ADDR_W-1:0]     iss_addr
);
  localparam int NREG = 1 << ADDR_W;
  localparam int NB   = DATA_W / 8;

  logic [NREG-1:0][DATA_W-1:0] regs;
  logic [NREG-1:0]             busy;

  // Storage and scoreboard update; issue is applied after the write clear
  // so a register retired and re-issued in one cycle stays busy
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
      busy <= '0;
    end else begin
      if (we && waddr != '0) begin
        for (int b = 0; b < NB; b++)
          if (wbe[b]) regs[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
      if (we) busy[waddr] <= 1'b0;
      if (iss && iss_addr != '0) busy[iss_addr] <= 1'b1;
    end
  end

  genvar k;
  generate
    for (k = 0; k < NRD; k++) begin : g_rd
      regfile_sb_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
        .regs  (regs),
        .busy  (busy),
        .raddr (raddr[k*ADDR_W +: ADDR_W]),
        .we    (we),
        .waddr (waddr),
        .wbe   (wbe),
        .wdata (wdata),
        .rdata (rdata[k*DATA_W +: DATA_W]),
        .rbusy (rbusy[k])
      );
    end
  endgenerate
endmodule
